// File: rtl/perceptron_trainer.sv
// Training controller for a 3-input FP16 perceptron: owns the sample store and weights,
// sequences the external sum/activation/update datapath and repeats epochs until clean or limit.
module perceptron_trainer #(
    parameter int TAM       = 16,
    parameter int N_SAMPLES = 4,
    parameter int AW        = 2,
    parameter int SETTLE    = 2,
    parameter int MAX_EPOCH = 16,
    parameter int EW        = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            load_we,
    input  logic [AW-1:0]   load_addr,
    input  logic [TAM-1:0]  load_in0,
    input  logic [TAM-1:0]  load_in1,
    input  logic [TAM-1:0]  load_in2,
    input  logic [TAM-1:0]  load_d,
    input  logic [TAM-1:0]  w_init0,
    input  logic [TAM-1:0]  w_init1,
    input  logic [TAM-1:0]  w_init2,
    output logic [TAM-1:0]  dp_in0,
    output logic [TAM-1:0]  dp_in1,
    output logic [TAM-1:0]  dp_in2,
    output logic [TAM-1:0]  dp_w0,
    output logic [TAM-1:0]  dp_w1,
    output logic [TAM-1:0]  dp_w2,
    output logic [TAM-1:0]  dp_d,
    output logic            calc_en,
    output logic            upd_en,
    input  logic [TAM-1:0]  y_in,
    input  logic [TAM-1:0]  w_upd0,
    input  logic [TAM-1:0]  w_upd1,
    input  logic [TAM-1:0]  w_upd2,
    output logic            busy,
    output logic            done,
    output logic            converged,
    output logic [EW-1:0]   epoch_cnt,
    output logic [AW:0]     err_cnt
);

    localparam int CW = $clog2(SETTLE + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_CALC  = 3'd2,
        S_EVAL  = 3'd3,
        S_UPD   = 3'd4,
        S_NEXT  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t                 state_r;
    logic [CW-1:0]          cnt_r;
    logic [AW-1:0]          idx_r;
    logic [4*TAM-1:0]       mem_r [N_SAMPLES];

    logic                   load_ok_s;
    logic                   last_idx_s;
    logic                   last_epoch_s;
    logic                   settle_last_s;
    logic [EW-1:0]          epoch_inc_s;

    assign load_ok_s     = load_we && !busy && ({1'b0, load_addr} < (AW+1)'(N_SAMPLES));
    assign last_idx_s    = (idx_r == AW'(N_SAMPLES - 1));
    assign settle_last_s = (cnt_r == CW'(SETTLE - 1));
    // Saturating epoch increment; the limit test uses the pre-increment count plus one.
    assign epoch_inc_s   = (epoch_cnt == {EW{1'b1}}) ? epoch_cnt : epoch_cnt + EW'(1);
    assign last_epoch_s  = (({1'b0, epoch_cnt} + (EW+1)'(1)) == (EW+1)'(MAX_EPOCH));

    // Sample store: written only while idle/done, never cleared by reset.
    always_ff @(posedge clk) begin
        if (load_ok_s) begin
            mem_r[load_addr] <= {load_in0, load_in1, load_in2, load_d};
        end
    end

    // Sequencer with registered datapath controls, weights and status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= S_IDLE;
            cnt_r     <= '0;
            idx_r     <= '0;
            dp_in0    <= '0;
            dp_in1    <= '0;
            dp_in2    <= '0;
            dp_d      <= '0;
            dp_w0     <= '0;
            dp_w1     <= '0;
            dp_w2     <= '0;
            calc_en   <= 1'b0;
            upd_en    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            converged <= 1'b0;
            epoch_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        dp_w0     <= w_init0;
                        dp_w1     <= w_init1;
                        dp_w2     <= w_init2;
                        idx_r     <= '0;
                        epoch_cnt <= '0;
                        err_cnt   <= '0;
                        done      <= 1'b0;
                        converged <= 1'b0;
                        busy      <= 1'b1;
                        state_r   <= S_FETCH;
                    end else begin
                        state_r   <= state_r;
                    end
                end
                S_FETCH: begin
                    {dp_in0, dp_in1, dp_in2, dp_d} <= mem_r[idx_r];
                    cnt_r   <= '0;
                    calc_en <= 1'b1;
                    state_r <= S_CALC;
                end
                S_CALC: begin
                    if (settle_last_s) begin
                        state_r <= S_EVAL;
                    end else begin
                        cnt_r   <= cnt_r + CW'(1);
                    end
                end
                S_EVAL: begin
                    // Bitwise compare: +0 and -0 are deliberately treated as different.
                    if (y_in != dp_d) begin
                        cnt_r   <= '0;
                        upd_en  <= 1'b1;
                        state_r <= S_UPD;
                    end else begin
                        calc_en <= 1'b0;
                        state_r <= S_NEXT;
                    end
                end
                S_UPD: begin
                    if (settle_last_s) begin
                        dp_w0   <= w_upd0;
                        dp_w1   <= w_upd1;
                        dp_w2   <= w_upd2;
                        err_cnt <= err_cnt + (AW+1)'(1);
                        calc_en <= 1'b0;
                        upd_en  <= 1'b0;
                        state_r <= S_NEXT;
                    end else begin
                        cnt_r   <= cnt_r + CW'(1);
                    end
                end
                S_NEXT: begin
                    if (!last_idx_s) begin
                        idx_r   <= idx_r + AW'(1);
                        state_r <= S_FETCH;
                    end else begin
                        epoch_cnt <= epoch_inc_s;
                        if (err_cnt == '0) begin
                            converged <= 1'b1;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            state_r   <= S_DONE;
                        end else if (last_epoch_s) begin
                            converged <= 1'b0;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            state_r   <= S_DONE;
                        end else begin
                            idx_r     <= '0;
                            err_cnt   <= '0;
                            state_r   <= S_FETCH;
                        end
                    end
                end
                default: begin
                    calc_en <= 1'b0;
                    upd_en  <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_perceptron_trainer.sv
// Directed bench for perceptron_trainer with a behavioural datapath stand-in whose
// classification result is forced per test mode.
module tb_perceptron_trainer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        load_we = 1'b0;
    logic [1:0]  load_addr = 2'd0;
    logic [15:0] load_in0 = 16'h0000, load_in1 = 16'h0000, load_in2 = 16'h0000, load_d = 16'h0000;
    logic [15:0] w_init0 = 16'h3400, w_init1 = 16'h3400, w_init2 = 16'hBC00;
    logic [15:0] dp_in0, dp_in1, dp_in2, dp_w0, dp_w1, dp_w2, dp_d;
    logic        calc_en, upd_en, busy, done, converged;
    logic [15:0] y_in, w_upd0, w_upd1, w_upd2;
    logic [7:0]  epoch_cnt;
    logic [2:0]  err_cnt;

    int          n_checks = 0;
    int          n_errors = 0;
    int          mode = 0;
    int          upd_cycles = 0;
    int          cyc;
    logic        mis;

    perceptron_trainer dut (
        .clk(clk), .rst(rst), .start(start), .load_we(load_we), .load_addr(load_addr),
        .load_in0(load_in0), .load_in1(load_in1), .load_in2(load_in2), .load_d(load_d),
        .w_init0(w_init0), .w_init1(w_init1), .w_init2(w_init2),
        .dp_in0(dp_in0), .dp_in1(dp_in1), .dp_in2(dp_in2),
        .dp_w0(dp_w0), .dp_w1(dp_w1), .dp_w2(dp_w2), .dp_d(dp_d),
        .calc_en(calc_en), .upd_en(upd_en), .y_in(y_in),
        .w_upd0(w_upd0), .w_upd1(w_upd1), .w_upd2(w_upd2),
        .busy(busy), .done(done), .converged(converged),
        .epoch_cnt(epoch_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Datapath stand-in: mode 1 misclassifies only sample (1,0) in the first epoch, mode 2 always.
    always_comb begin
        case (mode)
            1:       mis = (epoch_cnt == 8'd0) && (dp_in0 == 16'h3C00) && (dp_in1 == 16'h0000);
            2:       mis = 1'b1;
            default: mis = 1'b0;
        endcase
        y_in = mis ? (dp_d ^ 16'h3C00) : dp_d;
        if (mode == 1) begin
            w_upd0 = 16'h3800; w_upd1 = 16'h3800; w_upd2 = 16'hB800;
        end else begin
            w_upd0 = 16'h1111; w_upd1 = 16'h2222; w_upd2 = 16'h3333;
        end
    end

    always @(negedge clk) if (upd_en) upd_cycles++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_sample(input logic [1:0] a, input logic [15:0] i0, input logic [15:0] i1,
                               input logic [15:0] d);
        @(negedge clk);
        load_we = 1'b1; load_addr = a; load_in0 = i0; load_in1 = i1; load_in2 = 16'h3C00; load_d = d;
        @(posedge clk); #1;
        load_we = 1'b0;
    endtask

    // Pulse start, then count edges until done; optionally inject start+load while busy.
    task automatic run(input int max_cyc, input bit inject, output int n);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        upd_cycles = 0;
        n = 0;
        while (!done && n < max_cyc) begin
            if (inject && n == 3) begin
                start = 1'b1; load_we = 1'b1; load_addr = 2'd3;
                load_in0 = 16'hFFFF; load_in1 = 16'hFFFF; load_d = 16'hFFFF;
            end
            @(posedge clk); #1;
            start = 1'b0; load_we = 1'b0;
            n++;
        end
        if (!done) check_eq("run_timeout", 32'(n), 32'(max_cyc + 1));
    endtask

    initial begin
        // Reset state, and start ignored while reset is held
        #2;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_en", 32'({calc_en, upd_en}), 32'd0);
        check_eq("rst_w", 32'({dp_w0, dp_w1}), 32'd0);
        check_eq("rst_cnts", 32'({epoch_cnt, err_cnt, converged}), 32'd0);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check_eq("rst_start_ignored", 32'(busy), 32'd0);
        rst = 1'b0;

        load_sample(2'd0, 16'h0000, 16'h0000, 16'h0000);
        load_sample(2'd1, 16'h0000, 16'h3C00, 16'h0000);
        load_sample(2'd2, 16'h3C00, 16'h0000, 16'h0000);
        load_sample(2'd3, 16'h3C00, 16'h3C00, 16'h3C00);

        // Always-correct datapath: one clean epoch of 4 x 5 cycles
        mode = 0;
        run(100, 1'b0, cyc);
        check_eq("clean_cycles", 32'(cyc), 32'd20);
        check_eq("clean_epoch", 32'(epoch_cnt), 32'd1);
        check_eq("clean_err", 32'(err_cnt), 32'd0);
        check_eq("clean_conv", 32'(converged), 32'd1);
        check_eq("clean_w", 32'({dp_w0, dp_w1}), 32'h34003400);
        check_eq("clean_w2", 32'(dp_w2), 32'h0000BC00);
        check_eq("clean_idle_en", 32'({calc_en, upd_en, busy}), 32'd0);

        // One misclassification in epoch 1, clean epoch 2
        mode = 1;
        run(200, 1'b0, cyc);
        check_eq("one_err_cycles", 32'(cyc), 32'd42);
        check_eq("one_err_upd_cycles", 32'(upd_cycles), 32'd2);
        check_eq("one_err_epoch", 32'(epoch_cnt), 32'd2);
        check_eq("one_err_conv", 32'(converged), 32'd1);
        check_eq("one_err_err", 32'(err_cnt), 32'd0);
        check_eq("one_err_w", 32'({dp_w0, dp_w1}), 32'h38003800);
        check_eq("one_err_w2", 32'(dp_w2), 32'h0000B800);

        // Never converges: epoch limit, 16 x 4 x 7 cycles
        mode = 2;
        run(1000, 1'b0, cyc);
        check_eq("limit_cycles", 32'(cyc), 32'd448);
        check_eq("limit_epoch", 32'(epoch_cnt), 32'd16);
        check_eq("limit_err", 32'(err_cnt), 32'd4);
        check_eq("limit_conv", 32'(converged), 32'd0);
        check_eq("limit_upd_cycles", 32'(upd_cycles), 32'd128);
        check_eq("limit_w", 32'({dp_w0, dp_w2}), 32'h11113333);

        // start and load_we while busy are ignored; last sample fetched after the attempt
        mode = 0;
        run(100, 1'b1, cyc);
        check_eq("busy_no_restart", 32'(cyc), 32'd20);
        check_eq("busy_mem_in", 32'({dp_in0, dp_in1}), 32'h3C003C00);
        check_eq("busy_mem_d", 32'(dp_d), 32'h00003C00);
        run(100, 1'b0, cyc);
        check_eq("rerun_mem_d", 32'({dp_in1, dp_d}), 32'h3C003C00);

        // Reset during first UPD cycle
        mode = 2;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        cyc = 0;
        while (!upd_en && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_eq("reach_upd", 32'(upd_en), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("midrst_en", 32'({upd_en, calc_en}), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_w", 32'({dp_w0, dp_w2}), 32'd0);
        @(negedge clk); rst = 1'b0;
        mode = 0;
        run(100, 1'b0, cyc);
        check_eq("after_rst_cycles", 32'(cyc), 32'd20);
        check_eq("after_rst_w", 32'({dp_w0, dp_w2}), 32'h3400BC00);
        check_eq("after_rst_conv", 32'(converged), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/perceptron_trainer.md
Name: perceptron_trainer

Overview:
- Sequential training controller for the 3-input FP16 perceptron datapath: neuron-sum, step-activation and weight-update units.
- Stores a small training set and owns the three weight registers.
- Drives the datapath one sample at a time, waits for its combinational FP16 logic to settle, and commits updated weights on misclassification.
- Repeats epochs until an error-free epoch or an epoch limit; sits between the host/testbench loader and the neuron datapath.

Parameters:
- TAM, 16, data width (IEEE half precision).
- N_SAMPLES, 4, training-set depth.
- AW, 2, sample address width (2^AW >= N_SAMPLES).
- SETTLE, 2, cycles each enable is held before the datapath result is sampled (>=1).
- MAX_EPOCH, 16, epoch limit.
- EW, 8, epoch counter width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; accepted only in IDLE or DONE.
- load_we  in  1  sample write strobe; ignored while busy.
- load_addr  in  AW  sample index.
- load_in0, load_in1, load_in2  in  TAM  sample inputs (in2 normally bias 16'h3C00).
- load_d  in  TAM  desired output (16'h3C00 or 16'h0000).
- w_init0..2  in  TAM  initial weights, latched on accepted start.
- dp_in0..2  out  TAM  current sample inputs to the datapath.
- dp_w0..2  out  TAM  current weights to the datapath.
- dp_d  out  TAM  current desired output.
- calc_en  out  1  enable for sum and activation.
- upd_en  out  1  enable for weight update.
- y_in  in  TAM  activation result from the datapath.
- w_upd0..2  in  TAM  updated weights from the datapath.
- busy  out  1  high from FETCH through NEXT.
- done  out  1  high in DONE; cleared by accepted start.
- converged  out  1  valid with done; 1 means the last epoch was error-free.
- epoch_cnt  out  EW  number of epochs completed.
- err_cnt  out  AW+1  misclassifications in the current/last epoch.

Behaviour:
- Reset:
  - All outputs, weight registers, counters, index and FSM go to 0/IDLE.
  - Sample memory content is undefined after reset; it is not cleared.
- Loading: when load_we=1 and busy=0, mem[load_addr] <= {in0,in1,in2,d} on the next edge. Addresses >= N_SAMPLES are dropped.
- Accepted start (in IDLE or DONE):
  - Weights <= w_init.
  - idx, epoch_cnt, err_cnt <= 0; done, converged <= 0.
  - FSM -> FETCH.
  - Start is ignored in all other states.
- FETCH (1 cycle): dp_in*/dp_d <= mem[idx]; -> CALC.
- CALC (SETTLE cycles): calc_en=1; -> EVAL.
- EVAL (1 cycle): calc_en stays 1.
  - y_in is compared to dp_d bitwise; +0 and -0 count as different, and the datapath must produce canonical values.
  - Mismatch -> UPD; match -> NEXT.
- UPD (SETTLE cycles): upd_en=1 and calc_en=1.
  - On the last cycle: weights <= w_upd0..2 and err_cnt += 1; -> NEXT.
- NEXT (1 cycle):
  - If idx != N_SAMPLES-1: idx += 1; -> FETCH.
  - Else: epoch_cnt += 1, then:
    - If err_cnt == 0: converged=1; -> DONE.
    - Else if epoch_cnt+1 == MAX_EPOCH: converged=0; -> DONE.
    - Else: idx=0, err_cnt=0; -> FETCH.
- DONE:
  - done=1; weights, err_cnt and epoch_cnt hold.
  - dp_w* keep presenting the final weights; enables are 0.
- calc_en and upd_en are 0 outside the states listed above.
- Each enable is registered (glitch-free) and de-asserts the cycle after its state is left.
- Latency per sample: 3+SETTLE cycles on a correct classification; 3+2*SETTLE on an error.
- epoch_cnt saturates at 2^EW-1 and never wraps.
- Simultaneous start and load_we in IDLE: both take effect. The write lands the same edge; samples are first read one cycle later in FETCH, so the new data is used.
- Reset mid-operation (any state): immediate return to IDLE. Weights go to 0, no partial commit, enables drop asynchronously.

Test Plan:
- Reset in IDLE -> all outputs 0; toggle start with rst=1 -> FSM stays IDLE.
- Load 4 AND samples, datapath model always returns y_in=dp_d, SETTLE=2, start -> done 20 cycles after start, epoch_cnt=1, err_cnt=0, converged=1, dp_w = w_init.
- Model mismatches only epoch 1 sample 2 with w_upd={16'h3800,16'h3800,16'hB800} -> that sample takes 7 cycles with upd_en high 2 cycles; weights updated; epoch 2 clean -> epoch_cnt=2, converged=1.
- Model always mismatches -> done after MAX_EPOCH=16 epochs, epoch_cnt=16, err_cnt=4, converged=0.
- start and load_we pulsed while busy -> no restart, memory unchanged (readback in a second run shows the original data).
- Assert rst during UPD cycle 1 -> upd_en low immediately, weights 0, busy 0; a subsequent start runs normally from w_init.
